anita3_event_buffer_writer: RTL and testbench
=============================================

# anita3_event_buffer_writer

Write-side sequencer for the TURF event buffer RAM. Accepts a stream of 16-bit event words from the event builder and places each event in the next free 64-word buffer slot. Drives the buffer RAM write port (address, data, write enable) and the end-of-event strobe. Tracks slot occupancy against read-side releases (`clear_evt_i`) and back-pressures the source when every slot is full.

## Interface
- `NUM_BUFFERS`, default 2; number of buffer slots; legal values are 2 or 4.
- `EVENT_WORDS`, default 64; maximum words per event; must be 1..64.
- `clk33_i`  in  1  33 MHz system clock; all logic is on this clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `evt_dat_i`  in  16  event word.
- `evt_valid_i`  in  1  `evt_dat_i` is valid.
- `evt_last_i`  in  1  qualifies the final word of an event.
- `evt_ready_o`  out  1  block accepts a word this cycle.
- `event_wr_addr_o`  out  8  RAM write address, `{slot[1:0], word[5:0]}`.
- `event_wr_dat_o`  out  16  RAM write data.
- `event_wr_o`  out  1  RAM write enable.
- `event_done_o`  out  1  one-cycle end-of-event strobe; `event_wr_addr_o[7:6]` holds the completed slot.
- `clear_evt_i`  in  1  read side released its oldest slot.
- `write_buffer_o`  out  2  slot currently being filled, or the next slot to be filled.
- `occupancy_o`  out  3  number of filled, unreleased slots.
- `full_o`  out  1  `occupancy_o == NUM_BUFFERS`.
- `err_trunc_o`  out  1  sticky flag: an event exceeded `EVENT_WORDS`.
- `err_underflow_o`  out  1  sticky flag: `clear_evt_i` arrived with `occupancy_o == 0`.

## Operation
- States: IDLE, WRITE, FLUSH, DONE, DISCARD.
- `evt_ready_o = (state == WRITE) || (state == DISCARD)`. It is decoded directly from the state register.
- A word is accepted when `evt_valid_i && evt_ready_o`.
- IDLE:
  - If `occupancy_o < NUM_BUFFERS`, go to WRITE and clear `word_cnt` to 0.
  - Otherwise stay in IDLE.
- WRITE: on each accepted word:
  - Register `event_wr_dat_o <= evt_dat_i`.
  - Register `event_wr_addr_o <= {write_buffer_o, word_cnt}`.
  - Register `event_wr_o <= 1`.
  - Increment `word_cnt`.
  - If `evt_last_i` is set, go to FLUSH.
  - Else if `word_cnt == EVENT_WORDS-1`, go to FLUSH, set `err_trunc_o`, and mark the event as truncated.
- FLUSH: the final write is presented; go to DONE.
- DONE:
  - `event_done_o = 1` and `event_wr_o = 0`; `event_wr_addr_o` is held.
  - At the end of the cycle, `write_buffer_o` advances by 1 modulo `NUM_BUFFERS`, and occupancy increments.
  - Next state is DISCARD if the event was truncated, else IDLE.
- DISCARD: accepted words are dropped and produce no writes. Go to IDLE when a word with `evt_last_i` is accepted.
- Occupancy:
  - Increments on DONE; decrements on `clear_evt_i` when nonzero.
  - DONE and `clear_evt_i` in the same cycle leave it unchanged.
  - `clear_evt_i` at 0 is ignored for counting and sets `err_underflow_o`.
- Slots are filled in ring order 0, 1, (2, 3). Release order is assumed to match, so no read pointer is kept.
- With `NUM_BUFFERS = 2`, bit 1 of `write_buffer_o` is always 0.
- A short event writes only its words. Words past `evt_last_i` in the slot keep stale data.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs go to 0: `evt_ready_o`, `event_wr_o`, `event_done_o`, `event_wr_addr_o`, `event_wr_dat_o`, `write_buffer_o`, `occupancy_o`, `full_o`, both error flags.
  - A partial event is abandoned without `event_done_o`.
  - Sticky flags clear only on reset.

## Timing
- Word accepted at edge N → `event_wr_o` / address / data valid during cycle N+1 (one-cycle latency). One word per cycle is sustained.
- Last word accepted at N → write during N+1 (FLUSH) → `event_done_o` during N+2 (DONE) → IDLE at N+3.
- `evt_ready_o` is low from N+1 to N+3 inclusive.
- Earliest next acceptance is N+4, and only if a slot is free.
- The occupancy increment is visible from N+3.
- `clear_evt_i` in cycle M: occupancy is lower from M+1. A stalled IDLE can enter WRITE at M+1, so `evt_ready_o` is high from M+2.
- `full_o` and `occupancy_o` are registered.

## Test plan
- **Single event:** after reset, feed 64 words 0x0000..0x003F with last on the final word.
  - Writes go to addresses 0x00..0x3F in consecutive cycles.
  - `event_done_o` pulses two cycles after the last acceptance, with `addr[7:6] = 0`.
  - Afterwards `occupancy_o = 1` and `write_buffer_o = 1`.
- **Full back-pressure (`NUM_BUFFERS = 2`):** send three 4-word events.
  - The first two land in slots 0 and 1; `full_o = 1`; `evt_ready_o` stays 0.
  - Pulse `clear_evt_i`: the third event is written to slot 0 at addresses 0x00..0x03.
- **Truncation:** feed 70 words with last on word 69.
  - 64 writes occur and `event_done_o` pulses.
  - `err_trunc_o = 1`.
  - The remaining 6 words are accepted with no write. The next event starts in slot 1 at address 0x40.
- **Simultaneous events:** assert `clear_evt_i` in the same cycle as DONE while `occupancy_o = 1`. `occupancy_o` stays 1.
- **Underflow:** pulse `clear_evt_i` after reset. `occupancy_o` stays 0 and `err_underflow_o = 1`.
- **Reset mid-event:** assert `rst_i` after 10 words of an event.
  - All outputs are 0 immediately; `event_done_o` never pulses.
  - The next event writes from address 0x00.

Source files
------------

// File: rtl/anita3_event_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module   : anita3_event_buffer_writer
// Purpose  : Write-side sequencer for the TURF event buffer RAM. Places each
//            incoming event (stream of 16-bit words) into the next free
//            64-word slot, emits an end-of-event strobe, tracks slot
//            occupancy against read-side releases and back-pressures the
//            source when every slot is full.
// Ports    : clk33_i / rst_i            - clock, async active-high reset
//            evt_dat_i/valid_i/last_i   - event word stream in
//            evt_ready_o                - stream back-pressure
//            event_wr_addr_o/dat_o/wr_o - buffer RAM write port
//            event_done_o               - end-of-event strobe (slot in addr[7:6])
//            clear_evt_i                - read side released oldest slot
//            write_buffer_o             - slot being / to be filled
//            occupancy_o, full_o        - filled, unreleased slot count
//            err_trunc_o, err_underflow_o - sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module anita3_event_buffer_writer #(
  parameter int NUM_BUFFERS = 2,
  parameter int EVENT_WORDS = 64
) (
  input  logic        clk33_i,
  input  logic        rst_i,
  input  logic [15:0] evt_dat_i,
  input  logic        evt_valid_i,
  input  logic        evt_last_i,
  output logic        evt_ready_o,
  output logic [7:0]  event_wr_addr_o,
  output logic [15:0] event_wr_dat_o,
  output logic        event_wr_o,
  output logic        event_done_o,
  input  logic        clear_evt_i,
  output logic [1:0]  write_buffer_o,
  output logic [2:0]  occupancy_o,
  output logic        full_o,
  output logic        err_trunc_o,
  output logic        err_underflow_o
);

  localparam logic [5:0] LAST_WORD = 6'(EVENT_WORDS - 1);
  localparam logic [2:0] NUM_SLOTS = 3'(NUM_BUFFERS);
  localparam logic [1:0] LAST_SLOT = 2'(NUM_BUFFERS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    FLUSH   = 3'd2,
    DONE    = 3'd3,
    DISCARD = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        trunc_hit;
  logic [5:0]  word_cnt;
  logic        truncated;
  logic        occ_inc;
  logic        occ_dec;
  logic [2:0]  occ_next;

  // State register
  always_ff @(posedge clk33_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_next   = state;
    trunc_hit    = 1'b0;
    evt_ready_o  = (state == WRITE) || (state == DISCARD);
    event_done_o = (state == DONE);
    accept       = evt_valid_i && evt_ready_o;
    case (state)
      IDLE: begin
        if (occupancy_o < NUM_SLOTS) state_next = WRITE;
      end
      WRITE: begin
        if (accept) begin
          if (evt_last_i) begin
            state_next = FLUSH;
          end else if (word_cnt == LAST_WORD) begin
            // Slot is exhausted before the source signalled the end.
            state_next = FLUSH;
            trunc_hit  = 1'b1;
          end
        end
      end
      FLUSH:   state_next = DONE;
      DONE:    state_next = truncated ? DISCARD : IDLE;
      DISCARD: begin
        if (accept && evt_last_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A release against an empty buffer is not counted; completion and a
  // valid release in the same cycle cancel.
  always_comb begin
    occ_inc  = (state == DONE);
    occ_dec  = clear_evt_i && (occupancy_o != 3'd0);
    occ_next = occupancy_o;
    if (occ_inc && !occ_dec)      occ_next = occupancy_o + 3'd1;
    else if (!occ_inc && occ_dec) occ_next = occupancy_o - 3'd1;
  end

  // Datapath, slot pointer, occupancy and flags
  always_ff @(posedge clk33_i or posedge rst_i) begin
    if (rst_i) begin
      word_cnt        <= 6'd0;
      truncated       <= 1'b0;
      event_wr_o      <= 1'b0;
      event_wr_addr_o <= 8'd0;
      event_wr_dat_o  <= 16'd0;
      write_buffer_o  <= 2'd0;
      occupancy_o     <= 3'd0;
      full_o          <= 1'b0;
      err_trunc_o     <= 1'b0;
      err_underflow_o <= 1'b0;
    end else begin
      event_wr_o <= 1'b0;
      if (state == IDLE) begin
        word_cnt  <= 6'd0;
        truncated <= 1'b0;
      end
      if ((state == WRITE) && accept) begin
        event_wr_o      <= 1'b1;
        event_wr_dat_o  <= evt_dat_i;
        event_wr_addr_o <= {write_buffer_o, word_cnt};
        word_cnt        <= word_cnt + 6'd1;
      end
      if (trunc_hit) begin
        truncated   <= 1'b1;
        err_trunc_o <= 1'b1;
      end
      if (state == DONE) begin
        write_buffer_o <= (write_buffer_o == LAST_SLOT) ? 2'd0 : write_buffer_o + 2'd1;
      end
      occupancy_o <= occ_next;
      full_o      <= (occ_next == NUM_SLOTS);
      if (clear_evt_i && (occupancy_o == 3'd0)) err_underflow_o <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_anita3_event_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_anita3_event_buffer_writer
// Purpose  : Directed self-checking bench for anita3_event_buffer_writer
//            (NUM_BUFFERS = 2, EVENT_WORDS = 64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_anita3_event_buffer_writer;

  logic        clk33 = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] evt_dat = 16'd0;
  logic        evt_valid = 1'b0;
  logic        evt_last = 1'b0;
  logic        clear_evt = 1'b0;
  logic        evt_ready_o;
  logic [7:0]  event_wr_addr_o;
  logic [15:0] event_wr_dat_o;
  logic        event_wr_o;
  logic        event_done_o;
  logic [1:0]  write_buffer_o;
  logic [2:0]  occupancy_o;
  logic        full_o;
  logic        err_trunc_o;
  logic        err_underflow_o;

  anita3_event_buffer_writer #(.NUM_BUFFERS(2), .EVENT_WORDS(64)) dut (
    .clk33_i         (clk33),
    .rst_i           (rst),
    .evt_dat_i       (evt_dat),
    .evt_valid_i     (evt_valid),
    .evt_last_i      (evt_last),
    .evt_ready_o     (evt_ready_o),
    .event_wr_addr_o (event_wr_addr_o),
    .event_wr_dat_o  (event_wr_dat_o),
    .event_wr_o      (event_wr_o),
    .event_done_o    (event_done_o),
    .clear_evt_i     (clear_evt),
    .write_buffer_o  (write_buffer_o),
    .occupancy_o     (occupancy_o),
    .full_o          (full_o),
    .err_trunc_o     (err_trunc_o),
    .err_underflow_o (err_underflow_o)
  );

  always #15 clk33 = ~clk33;

  int cyc = 0;
  always @(posedge clk33) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, away from the active edge.
  logic [7:0]  wr_addr_q[$];
  logic [15:0] wr_dat_q[$];
  int          wr_cyc_q[$];
  int          done_cnt = 0;
  logic [1:0]  done_slot = 2'd0;
  int          done_cyc = 0;
  int          acc_cnt = 0;
  int          last_acc_cyc = 0;
  int          clear_cyc = 0;
  int          ready_rise_cyc = 0;
  logic        prev_ready = 1'b0;

  always @(negedge clk33) begin
    if (event_wr_o) begin
      wr_addr_q.push_back(event_wr_addr_o);
      wr_dat_q.push_back(event_wr_dat_o);
      wr_cyc_q.push_back(cyc);
    end
    if (event_done_o) begin
      done_cnt  = done_cnt + 1;
      done_slot = event_wr_addr_o[7:6];
      done_cyc  = cyc;
    end
    if (evt_valid && evt_ready_o) begin
      acc_cnt = acc_cnt + 1;
      if (evt_last) last_acc_cyc = cyc;
    end
    if (clear_evt) clear_cyc = cyc;
    if (evt_ready_o && !prev_ready) ready_rise_cyc = cyc;
    prev_ready = evt_ready_o;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk33);
      #1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    evt_valid = 1'b0;
    evt_last  = 1'b0;
    clear_evt = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Presents one word and returns just after the edge that accepted it.
  task automatic send_word(input logic [15:0] d, input logic last);
    int t;
    evt_valid = 1'b1;
    evt_dat   = d;
    evt_last  = last;
    t = 0;
    while (!evt_ready_o && t < 300) begin
      tick(1);
      t++;
    end
    if (!evt_ready_o) check("ready_timeout", 32'(evt_ready_o), 32'd1);
    else              tick(1);
  endtask

  task automatic send_event(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) send_word(base + 16'(i), i == n - 1);
    evt_valid = 1'b0;
    evt_last  = 1'b0;
  endtask

  // Checks n consecutive writes starting at queue index qi.
  task automatic check_writes(input string tag, input int qi, input int n,
                              input logic [7:0] a0, input logic [15:0] d0);
    for (int i = 0; i < n; i++)
      check(tag, {8'd0, wr_addr_q[qi+i], wr_dat_q[qi+i]}, {8'd0, a0 + 8'(i), d0 + 16'(i)});
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {16'd0, evt_ready_o, event_wr_o, event_done_o, write_buffer_o,
                occupancy_o, full_o, err_trunc_o, err_underflow_o, 3'd0}, 32'd0);
    check(tag, {8'd0, event_wr_addr_o, event_wr_dat_o}, 32'd0);
  endtask

  int wb;
  int db;
  int ab;

  initial begin
    // Reset state
    tick(2);
    check_all_zero("reset_state");
    rst = 1'b0;
    tick(1);

    // Underflow
    clear_evt = 1'b1;
    tick(1);
    clear_evt = 1'b0;
    tick(1);
    check("underflow_occ", 32'(occupancy_o), 32'd0);
    check("underflow_flag", 32'(err_underflow_o), 32'd1);
    do_reset();
    check("underflow_cleared", 32'(err_underflow_o), 32'd0);

    // Single 64-word event
    wb = wr_addr_q.size();
    send_event(64, 16'h0000);
    tick(6);
    check("single_nwr", 32'(wr_addr_q.size() - wb), 32'd64);
    check_writes("single_wr", wb, 64, 8'h00, 16'h0000);
    check("single_contig", 32'(wr_cyc_q[wb+63] - wr_cyc_q[wb]), 32'd63);
    check("single_done_cnt", 32'(done_cnt), 32'd1);
    check("single_done_slot", 32'(done_slot), 32'd0);
    check("single_done_lat", 32'(done_cyc - last_acc_cyc), 32'd2);
    check("single_ready_lat", 32'(ready_rise_cyc - last_acc_cyc), 32'd4);
    check("single_occ", 32'(occupancy_o), 32'd1);
    check("single_wbuf", 32'(write_buffer_o), 32'd1);
    check("single_full", 32'(full_o), 32'd0);
    check("single_trunc", 32'(err_trunc_o), 32'd0);

    // Release coinciding with DONE while one slot is occupied
    wb = wr_addr_q.size();
    send_event(4, 16'h0200);
    tick(1);
    check("sim_in_done", 32'(event_done_o), 32'd1);
    check("sim_occ_before", 32'(occupancy_o), 32'd1);
    clear_evt = 1'b1;
    tick(1);
    clear_evt = 1'b0;
    check("sim_occ_after", 32'(occupancy_o), 32'd1);
    check("sim_wbuf", 32'(write_buffer_o), 32'd0);
    check_writes("sim_wr", wb, 4, 8'h40, 16'h0200);
    check("sim_done_slot", 32'(done_slot), 32'd1);

    // Back-pressure with both slots full
    do_reset();
    send_event(4, 16'h0300);
    send_event(4, 16'h0310);
    tick(4);
    check("full_occ", 32'(occupancy_o), 32'd2);
    check("full_flag", 32'(full_o), 32'd1);
    check("full_ready", 32'(evt_ready_o), 32'd0);
    wb = wr_addr_q.size();
    fork
      send_event(4, 16'h0320);
      begin
        tick(20);
        check("full_stall_ready", 32'(evt_ready_o), 32'd0);
        check("full_stall_nwr", 32'(wr_addr_q.size() - wb), 32'd0);
        clear_evt = 1'b1;
        tick(1);
        clear_evt = 1'b0;
      end
    join
    tick(6);
    check("full_nwr", 32'(wr_addr_q.size() - wb), 32'd4);
    check_writes("full_wr", wb, 4, 8'h00, 16'h0320);
    check("full_done_slot", 32'(done_slot), 32'd0);
    check("full_clear_lat", 32'(ready_rise_cyc - clear_cyc), 32'd2);
    check("full_occ_end", 32'(occupancy_o), 32'd2);

    // Truncation: 70 words into a 64-word slot
    do_reset();
    wb = wr_addr_q.size();
    db = done_cnt;
    ab = acc_cnt;
    send_event(70, 16'h0400);
    tick(6);
    check("trunc_nwr", 32'(wr_addr_q.size() - wb), 32'd64);
    check_writes("trunc_wr", wb, 64, 8'h00, 16'h0400);
    check("trunc_done_cnt", 32'(done_cnt - db), 32'd1);
    check("trunc_done_slot", 32'(done_slot), 32'd0);
    check("trunc_flag", 32'(err_trunc_o), 32'd1);
    check("trunc_accepted", 32'(acc_cnt - ab), 32'd70);
    check("trunc_occ", 32'(occupancy_o), 32'd1);
    wb = wr_addr_q.size();
    send_event(2, 16'h0500);
    tick(6);
    check("trunc_next_nwr", 32'(wr_addr_q.size() - wb), 32'd2);
    check_writes("trunc_next_wr", wb, 2, 8'h40, 16'h0500);
    check("trunc_next_slot", 32'(done_slot), 32'd1);
    check("trunc_sticky", 32'(err_trunc_o), 32'd1);

    // Reset in the middle of an event
    do_reset();
    db = done_cnt;
    for (int i = 0; i < 10; i++) send_word(16'h0600 + 16'(i), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst_outputs");
    do_reset();
    tick(4);
    check("midrst_no_done", 32'(done_cnt - db), 32'd0);
    wb = wr_addr_q.size();
    send_event(3, 16'h0700);
    tick(6);
    check("midrst_nwr", 32'(wr_addr_q.size() - wb), 32'd3);
    check_writes("midrst_wr", wb, 3, 8'h00, 16'h0700);
    check("midrst_done_cnt", 32'(done_cnt - db), 32'd1);
    check("midrst_done_slot", 32'(done_slot), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
